div_ctrl: RTL
=============

Name: div_ctrl

Overview:
Sequencing controller for the unsigned fixed-point shift-subtract divider datapath. It runs a start/busy/valid handshake, drives the datapath load/shift/subtract strobes and the iteration counter (clear/enable), and monitors divide-by-zero and the overflow detector. It sits between the requesting unit and the divider datapath. The datapath, counter and overflow detector stay separate modules.

Parameters:
ITERS, 14, number of shift-subtract iterations per division; must match the iteration counter terminal count.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low; the only reset in the block.
start  input  1  request; sampled only in IDLE or DONE.
b_zero  input  1  divisor register equals zero (datapath comparator).
rem_ge_div  input  1  partial remainder >= divisor (datapath comparator).
cnt_co  input  1  iteration counter carry-out; high when the count equals ITERS-1.
ovf_in  input  1  overflow detector output.
ld_ab  output  1  load dividend and divisor registers; clear the quotient and remainder.
sclr_cnt  output  1  synchronous clear to the iteration counter.
cnt_en  output  1  iteration counter enable.
sh_en  output  1  shift the remainder and quotient left by one.
sub_wr  output  1  write the subtract result to the remainder and set quotient LSB to 1.
busy  output  1  operation in progress.
valid  output  1  result valid; one-cycle pulse.
dvz  output  1  sticky divide-by-zero flag.
ovf  output  1  sticky overflow flag.

Behaviour:
- States: IDLE, INIT, CHECK, ITER, DONE. The state is held in a registered enum; all outputs are decoded from state plus inputs.
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - All outputs are 0, including the dvz and ovf flags.
  - A reset mid-operation aborts the division with no valid pulse.
- IDLE: all strobes 0, busy=0. start=1 moves to INIT.
- INIT (1 cycle):
  - ld_ab=1 and sclr_cnt=1; dvz and ovf clear at the next edge.
  - busy=1. Next state is CHECK.
- CHECK (1 cycle):
  - busy=1.
  - b_zero=1: set dvz and go to DONE.
  - Otherwise go to ITER.
- ITER (ITERS cycles):
  - busy=1, cnt_en=1, sh_en=1, sub_wr=rem_ge_div.
  - ovf_in=1: set ovf and go to DONE. The iteration in that cycle still completes its strobes.
  - Else cnt_co=1: go to DONE.
  - Else stay in ITER.
  - If ovf_in and cnt_co are high together, ovf wins and the ovf flag is set.
- DONE (1 cycle):
  - valid=1, busy=0; dvz and ovf are held.
  - start=1: go straight to INIT (back-to-back operation).
  - Otherwise go to IDLE.
- Sticky flags: dvz and ovf hold through IDLE until the next INIT or a reset.
- start while busy (INIT, CHECK or ITER) is ignored and is not queued.
- Latency: start sampled at edge 0 gives INIT in cycle 1, CHECK in cycle 2, ITER in cycles 3..ITERS+2, and valid in cycle ITERS+3 (cycle 17 for the default).
  - Divide-by-zero: valid in cycle 3.
- Width rules: the controller carries no data; the counter width belongs to the datapath.

Decomposition:
- Shared package div_pkg holds:
  - the state enum div_state_t {IDLE, INIT, CHECK, ITER, DONE};
  - the constant DIV_ITERS=14, used as the ITERS default by both the counter and the controller.
- No sub-module. The block is one state register, a combinational next-state/output decode, and two flag flops.

Test Plan:
- Normal division: start pulse at edge 0, b_zero=0, ovf_in=0, counter14 connected -> busy high in cycles 1-16; cnt_en high for exactly 14 cycles; valid pulse in cycle 17; dvz=0, ovf=0.
- Divide-by-zero: b_zero=1, start at edge 0 -> ld_ab in cycle 1; dvz=1 and valid in cycle 3; cnt_en never asserted.
- Overflow abort: ovf_in forced high in the 5th ITER cycle (cycle 7) -> cnt_en asserted 5 times; valid and ovf=1 in cycle 8; ovf stays 1 in IDLE until the next start.
- Reset mid-operation: rst driven low in ITER cycle 8 -> all outputs 0 without a clock edge; after release, no valid pulse and the block accepts a new start.
- Back-to-back requests: start held high -> second INIT directly follows DONE (valid at cycles 17 and 34); start pulses during busy are ignored.
- sub_wr tracking: rem_ge_div toggled 1,0,1,... during ITER -> sub_wr mirrors it every cycle while sh_en stays 1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: controller state encoding
// and the default iteration count shared by the counter and the controller.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        ITER,
        DONE
    } div_state_t;

    localparam int unsigned DIV_ITERS = 14;

endpackage

// File: rtl/div_ctrl.sv
// Sequencing controller for the unsigned shift-subtract divider datapath:
// start/busy/valid handshake, datapath strobes and sticky error flags.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned ITERS = DIV_ITERS
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_zero,
    input  logic rem_ge_div,
    input  logic cnt_co,
    input  logic ovf_in,
    output logic ld_ab,
    output logic sclr_cnt,
    output logic cnt_en,
    output logic sh_en,
    output logic sub_wr,
    output logic busy,
    output logic valid,
    output logic dvz,
    output logic ovf
);

    // The iteration count is realised by the external counter's carry-out;
    // a zero-iteration divider cannot terminate through cnt_co.
    if (ITERS < 1) begin : g_iters_check
        $error("div_ctrl: ITERS must be at least 1");
    end

    div_state_t state_q, state_d;
    logic       dvz_q, dvz_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dvz_d    = dvz_q;
        ovf_d    = ovf_q;
        ld_ab    = 1'b0;
        sclr_cnt = 1'b0;
        cnt_en   = 1'b0;
        sh_en    = 1'b0;
        sub_wr   = 1'b0;
        busy     = 1'b0;
        valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                ld_ab    = 1'b1;
                sclr_cnt = 1'b1;
                busy     = 1'b1;
                dvz_d    = 1'b0;
                ovf_d    = 1'b0;
                state_d  = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (b_zero) begin
                    dvz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                busy   = 1'b1;
                cnt_en = 1'b1;
                sh_en  = 1'b1;
                sub_wr = rem_ge_div;
                // Overflow takes priority so a simultaneous terminal count still flags it.
                if (ovf_in) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_co) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (start) begin
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dvz = dvz_q;
    assign ovf = ovf_q;

endmodule
